// File: rtl/drum_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : drum_sequencer
// Purpose  : Turns timer ticks into drum bit-time / word-time sequencing with
//            run, halt-on-word-boundary and single-word step control.
// Revision : 1.0 - initial release
// ============================================================================
module drum_sequencer #(
    parameter int BITS  = 29,
    parameter int WORDS = 108,
    parameter int BW    = $clog2(BITS),
    parameter int WW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          run,
    input  logic          step,
    output logic          busy,
    output logic          bit_en,
    output logic [BW-1:0] bit_time,
    output logic [WW-1:0] word_time,
    output logic          word_start,
    output logic          word_end,
    output logic          origin,
    output logic          done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_STEP = 2'd2;

    localparam logic [BW-1:0] c_BIT_LAST  = BW'(BITS - 1);
    localparam logic [WW-1:0] c_WORD_LAST = WW'(WORDS - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [BW-1:0] r_bit_time;
    logic [WW-1:0] r_word_time;
    logic          r_done;
    logic          w_active;
    logic          w_bit_en;
    logic          w_word_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= (r_state != c_IDLE) && (w_next_state == c_IDLE);
        end
    end

    // Leaving RUN/STEP only on word_end is what keeps bit_time at 0 while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (run) begin
                    w_next_state = c_RUN;
                end else if (step) begin
                    w_next_state = c_STEP;
                end
            end
            c_RUN: begin
                if (w_word_end && !run) begin
                    w_next_state = c_IDLE;
                end
            end
            c_STEP: begin
                if (w_word_end) begin
                    w_next_state = run ? c_RUN : c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_active   = (r_state == c_RUN) || (r_state == c_STEP);
        w_bit_en   = tick && w_active;
        w_word_end = w_bit_en && (r_bit_time == c_BIT_LAST);
        busy       = (r_state != c_IDLE);
        bit_en     = w_bit_en;
        word_start = w_bit_en && (r_bit_time == '0);
        word_end   = w_word_end;
        origin     = w_bit_en && (r_bit_time == '0) && (r_word_time == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_time  <= '0;
            r_word_time <= '0;
        end else if (w_bit_en) begin
            if (r_bit_time == c_BIT_LAST) begin
                r_bit_time  <= '0;
                r_word_time <= (r_word_time == c_WORD_LAST) ? '0 : r_word_time + WW'(1);
            end else begin
                r_bit_time  <= r_bit_time + BW'(1);
            end
        end
    end

    assign bit_time  = r_bit_time;
    assign word_time = r_word_time;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_drum_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_drum_sequencer
// Purpose  : Self-checking bench: small geometry against a position model,
//            default geometry against revolution/word period properties.
// Revision : 1.0 - initial release
// ============================================================================
module tb_drum_sequencer;

    localparam int MB   = 4;
    localparam int MW   = 3;
    localparam int MREV = MB * MW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0, run = 1'b0, step = 1'b0;
    logic       busy, bit_en, word_start, word_end, origin, done;
    logic [1:0] bit_time, word_time;

    logic       tick_b = 1'b0, run_b = 1'b0, step_b = 1'b0;
    logic       b_busy, b_bit_en, b_word_start, b_word_end, b_origin, b_done;
    logic [4:0] b_bit_time;
    logic [6:0] b_word_time;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    drum_sequencer #(.BITS(MB), .WORDS(MW)) u_dut (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .step(step),
        .busy(busy), .bit_en(bit_en), .bit_time(bit_time), .word_time(word_time),
        .word_start(word_start), .word_end(word_end), .origin(origin), .done(done)
    );

    drum_sequencer u_big (
        .clk(clk), .rst(rst), .tick(tick_b), .run(run_b), .step(step_b),
        .busy(b_busy), .bit_en(b_bit_en), .bit_time(b_bit_time), .word_time(b_word_time),
        .word_start(b_word_start), .word_end(b_word_end), .origin(b_origin), .done(b_done)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: linear drum position 0..MREV-1 plus a mode (0 idle, 1 run, 2 step).
    int   m_pos = 0;
    int   m_mode = 0;
    bit   m_done = 1'b0;
    bit   mdl_be, mdl_we;
    int   mdl_bt, mdl_wt, mdl_next;

    always_comb begin
        mdl_bt   = m_pos % MB;
        mdl_wt   = m_pos / MB;
        mdl_be   = tick && (m_mode != 0);
        mdl_we   = mdl_be && (mdl_bt == MB - 1);
        mdl_next = m_mode;
        if (m_mode == 0) mdl_next = run ? 1 : (step ? 2 : 0);
        else if (mdl_we && (m_mode == 2 || !run)) mdl_next = run ? 1 : 0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pos  <= 0;
            m_mode <= 0;
            m_done <= 1'b0;
        end else begin
            m_mode <= mdl_next;
            m_done <= (m_mode != 0) && (mdl_next == 0);
            if (mdl_be) m_pos <= (m_pos + 1) % MREV;
        end
    end

    always @(negedge clk) begin
        chk("busy",       int'(busy),       int'(m_mode != 0));
        chk("bit_en",     int'(bit_en),     int'(mdl_be));
        chk("bit_time",   int'(bit_time),   mdl_bt);
        chk("word_time",  int'(word_time),  mdl_wt);
        chk("word_start", int'(word_start), int'(mdl_be && mdl_bt == 0));
        chk("word_end",   int'(word_end),   int'(mdl_we));
        chk("origin",     int'(origin),     int'(mdl_be && m_pos == 0));
        chk("done",       int'(done),       int'(m_done));
    end

    // Default geometry: period and range properties.
    bit big_on = 1'b0;
    int bcyc = 0, last_orig = 0, n_orig = 0, last_wend = 0, n_wend = 0;

    always @(negedge clk) begin
        if (big_on) begin
            bcyc++;
            chk("t6_bit_range",  int'(b_bit_time <= 5'd28),   1);
            chk("t6_word_range", int'(b_word_time <= 7'd107), 1);
            if (b_origin) begin
                if (n_orig > 0) chk("t6_origin_period", bcyc - last_orig, 3132);
                last_orig = bcyc;
                n_orig++;
            end
            if (b_word_end) begin
                if (n_wend > 0) chk("t6_word_end_period", bcyc - last_wend, 29);
                last_wend = bcyc;
                n_wend++;
            end
        end
    end

    task automatic setin(input logic t, input logic r, input logic s);
        tick = t; run = r; step = s;
        #2;
    endtask

    task automatic edge_;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; tick = 1'b0; run = 1'b0; step = 1'b0;
        edge_;
        edge_;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nbe, ndone;
        bit r_lvl;
        edge_;
        do_reset;

        // Single step, tick every cycle
        setin(0, 0, 1); chk("t1_idle_busy", int'(busy), 0); edge_;
        for (int i = 0; i < 4; i++) begin
            setin(1, 0, 0);
            chk("t1_bit_en",   int'(bit_en), 1);
            chk("t1_bit_time", int'(bit_time), i);
            chk("t1_start",    int'(word_start), int'(i == 0));
            chk("t1_end",      int'(word_end), int'(i == 3));
            chk("t1_origin",   int'(origin), int'(i == 0));
            edge_;
        end
        setin(0, 0, 0);
        chk("t1_busy", int'(busy), 0);
        chk("t1_done", int'(done), 1);
        chk("t1_word", int'(word_time), 1);
        chk("t1_bit",  int'(bit_time), 0);
        edge_;
        setin(1, 0, 0);
        chk("t1_done_clear", int'(done), 0);
        chk("t1_idle_tick",  int'(bit_en), 0);
        edge_;

        // Run for 13 ticks, tick every third cycle; tick on the start edge is dropped
        do_reset;
        setin(1, 1, 0); chk("t2_start_tick", int'(bit_en), 0); edge_;
        for (int k = 1; k <= 13; k++) begin
            setin(0, 1, 0); edge_;
            setin(0, 1, 0); edge_;
            setin(1, 1, 0);
            chk("t2_bit_en", int'(bit_en), 1);
            chk("t2_word",   int'(word_time), ((k - 1) / 4) % 3);
            chk("t2_origin", int'(origin), int'(k == 1 || k == 13));
            edge_;
        end

        // Drop run while bit 1 executes: bits 2 and 3 follow, then halt
        setin(1, 0, 0);
        chk("t3_bit1", int'(bit_time), 1);
        chk("t3_bit1_en", int'(bit_en), 1);
        edge_;
        nbe = 0; ndone = 0;
        for (int i = 0; i < 6; i++) begin
            setin(1, 0, 0);
            nbe += int'(bit_en);
            ndone += int'(done);
            edge_;
        end
        setin(1, 0, 0);
        chk("t3_bit_en_count", nbe, 2);
        chk("t3_done_count", ndone, 1);
        chk("t3_busy", int'(busy), 0);
        chk("t3_bit_hold", int'(bit_time), 0);
        chk("t3_word_hold", int'(word_time), 1);
        edge_;

        // run+step together, step during RUN, run raised during STEP
        do_reset;
        setin(0, 1, 1); edge_;
        setin(0, 1, 0); chk("t4_busy", int'(busy), 1); edge_;
        for (int i = 0; i < 6; i++) begin setin(1, 1, i == 2); edge_; end
        for (int i = 0; i < 10; i++) begin setin(1, 0, 0); if (!busy) break; edge_; end
        chk("t4_halt", int'(busy), 0);
        edge_;
        setin(0, 0, 1); edge_;
        setin(1, 0, 0); edge_;
        setin(1, 1, 0); edge_;
        for (int i = 0; i < 6; i++) begin
            setin(1, 1, 0);
            chk("t4_cont_busy", int'(busy), 1);
            chk("t4_cont_done", int'(done), 0);
            edge_;
        end
        for (int i = 0; i < 10; i++) begin setin(1, 0, 0); if (!busy) break; edge_; end
        chk("t4_halt2", int'(busy), 0);
        edge_;

        // Asynchronous reset at word 2 bit 2
        do_reset;
        setin(0, 1, 0); edge_;
        for (int i = 0; i < 10; i++) begin setin(1, 1, 0); edge_; end
        setin(1, 1, 0);
        chk("t5_word", int'(word_time), 2);
        chk("t5_bit",  int'(bit_time), 2);
        rst = 1'b1;
        #1;
        chk("t5_busy",   int'(busy), 0);
        chk("t5_bit_en", int'(bit_en), 0);
        chk("t5_bit0",   int'(bit_time), 0);
        chk("t5_word0",  int'(word_time), 0);
        chk("t5_done",   int'(done), 0);
        edge_;
        setin(0, 0, 0); chk("t5_no_done", int'(done), 0);
        rst = 1'b0;
        edge_;
        setin(0, 0, 1); edge_;
        setin(1, 0, 0);
        chk("t5_step_bit",    int'(bit_time), 0);
        chk("t5_step_word",   int'(word_time), 0);
        chk("t5_step_origin", int'(origin), 1);
        edge_;
        for (int i = 0; i < 4; i++) begin setin(1, 0, 0); edge_; end

        // Randomized traffic with occasional async resets
        r_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) r_lvl = ~r_lvl;
            setin(($urandom_range(0, 2) != 0), r_lvl, ($urandom_range(0, 7) == 0));
            rst = ($urandom_range(0, 299) == 0);
            edge_;
        end
        rst = 1'b0;

        // Default geometry, run held, tick every cycle
        do_reset;
        tick = 1'b0; run = 1'b0; step = 1'b0;
        tick_b = 1'b1; run_b = 1'b1;
        big_on = 1'b1;
        for (int i = 0; i < 3132 * 2 + 60; i++) edge_;
        big_on = 1'b0;
        chk("t6_origin_seen", int'(n_orig >= 3), 1);
        chk("t6_word_end_seen", int'(n_wend >= 200), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
